alu_ctrl_pipe: RTL and testbench

//  Parametrised, pipelined successor of the combinational ALU control decoder.

---
 rtl/alu_ctrl_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: ID-stage ALU control decode registered into the ID/EX
// boundary, with stall/flush handling and multi-cycle MULT/DIV sequencing.
// While a MULT/DIV occupies EX, hazard_stall_o back-pressures ID until the
// final EX cycle of that op.
module alu_ctrl_pipe #(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ex_valid_o,
  output logic [OP_W-1:0]    ex_op_o,
  output logic               ex_multi_o,
  output logic               ex_last_o,
  output logic               ex_illegal_o,
  output logic               hazard_stall_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic              ex_valid_r, valid_nxt;
  logic [OP_W-1:0]   ex_op_r, op_nxt;
  logic              ex_multi_r, multi_nxt;
  logic              ex_illegal_r, illegal_nxt;

  logic [OP_W-1:0]   dec_op_s;
  logic              dec_multi_s;
  logic              dec_long_s;
  logic [CNT_W-1:0]  dec_cnt_s;
  logic              dec_illegal_s;
  logic              advance_s;

  // Decode the ID instruction; unmatched encodings give op 0 and illegal.
  always_comb begin
    dec_op_s      = OP_W'(0);
    dec_multi_s   = 1'b0;
    dec_long_s    = 1'b0;
    dec_cnt_s     = CNT_W'(0);
    dec_illegal_s = 1'b0;
    case (opcode_i)
      OPC_W'(11): dec_op_s = OP_W'(5'h01);
      OPC_W'(4):  dec_op_s = OP_W'(5'h03);
      OPC_W'(5):  dec_op_s = OP_W'(5'h04);
      OPC_W'(7):  dec_op_s = OP_W'(5'h05);
      OPC_W'(3):  dec_op_s = OP_W'(5'h02);
      OPC_W'(2): begin
        case (funct_i)
          FUNCT_W'(6'h20),
          FUNCT_W'(6'h21),
          FUNCT_W'(6'h13): dec_op_s = OP_W'(5'h03);
          FUNCT_W'(6'h24): dec_op_s = OP_W'(5'h05);
          FUNCT_W'(6'h25): dec_op_s = OP_W'(5'h02);
          FUNCT_W'(6'h14): dec_op_s = OP_W'(5'h04);
          FUNCT_W'(6'h08): dec_op_s = OP_W'(5'h0b);
          FUNCT_W'(6'h27): dec_op_s = OP_W'(5'h0a);
          FUNCT_W'(6'h2a): dec_op_s = OP_W'(5'h08);
          FUNCT_W'(6'h2b): dec_op_s = OP_W'(5'h09);
          FUNCT_W'(6'h00): dec_op_s = OP_W'(5'h06);
          FUNCT_W'(6'h02): dec_op_s = OP_W'(5'h07);
          FUNCT_W'(6'h18): begin
            dec_op_s    = OP_W'(5'h0c);
            dec_multi_s = 1'b1;
            dec_long_s  = (MUL_LAT > 1);
            dec_cnt_s   = CNT_W'(MUL_LAT - 1);
          end
          FUNCT_W'(6'h1a): begin
            dec_op_s    = OP_W'(5'h0d);
            dec_multi_s = 1'b1;
            dec_long_s  = (DIV_LAT > 1);
            dec_cnt_s   = CNT_W'(DIV_LAT - 1);
          end
          default: dec_illegal_s = id_valid_i;
        endcase
      end
      default: dec_illegal_s = id_valid_i;
    endcase
  end

  // EX may take a new op when idle or on the final cycle of a multi-cycle op.
  assign advance_s = (state_r == IDLE) || (cnt_r == CNT_W'(0));

  // Next-state: flush beats stall beats normal advance / countdown.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    valid_nxt   = ex_valid_r;
    op_nxt      = ex_op_r;
    multi_nxt   = ex_multi_r;
    illegal_nxt = ex_illegal_r;
    if (flush_i) begin
      state_nxt   = IDLE;
      cnt_nxt     = CNT_W'(0);
      valid_nxt   = 1'b0;
      op_nxt      = OP_W'(0);
      multi_nxt   = 1'b0;
      illegal_nxt = 1'b0;
    end else if (stall_i) begin
      state_nxt = state_r;
    end else if (advance_s) begin
      valid_nxt   = id_valid_i;
      op_nxt      = id_valid_i ? dec_op_s : OP_W'(0);
      multi_nxt   = id_valid_i && dec_multi_s;
      illegal_nxt = id_valid_i && dec_illegal_s;
      if (id_valid_i && dec_multi_s && dec_long_s) begin
        state_nxt = MULTI;
        cnt_nxt   = dec_cnt_s;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_W'(0);
      end
    end else begin
      cnt_nxt = cnt_r - CNT_W'(1);
    end
  end

  // ID/EX pipeline registers and FSM state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_W'(0);
      ex_valid_r   <= 1'b0;
      ex_op_r      <= OP_W'(0);
      ex_multi_r   <= 1'b0;
      ex_illegal_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      ex_valid_r   <= valid_nxt;
      ex_op_r      <= op_nxt;
      ex_multi_r   <= multi_nxt;
      ex_illegal_r <= illegal_nxt;
    end
  end

  assign ex_valid_o     = ex_valid_r;
  assign ex_op_o        = ex_op_r;
  assign ex_multi_o     = ex_multi_r;
  assign ex_illegal_o   = ex_illegal_r;
  assign ex_last_o      = ex_valid_r && ((state_r == IDLE) || (cnt_r == CNT_W'(0)));
  assign hazard_stall_o = (state_r == MULTI) && (cnt_r != CNT_W'(0));

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: a cycle-level model tracking "EX cycles remaining"
// for the current op, compared on every falling edge, plus literal checks.
module tb_alu_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [3:0] opcode_i = 4'h0;
  logic [5:0] funct_i = 6'h00;
  logic       stall_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       ex_valid_o;
  logic [4:0] ex_op_o;
  logic       ex_multi_o;
  logic       ex_last_o;
  logic       ex_illegal_o;
  logic       hazard_stall_o;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  alu_ctrl_pipe #(
    .OPC_W(4), .FUNCT_W(6), .OP_W(5), .MUL_LAT(4), .DIV_LAT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .opcode_i(opcode_i),
    .funct_i(funct_i), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o), .ex_multi_o(ex_multi_o),
    .ex_last_o(ex_last_o), .ex_illegal_o(ex_illegal_o),
    .hazard_stall_o(hazard_stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  task automatic ref_decode(input logic [3:0] opc, input logic [5:0] f,
                            output logic [4:0] op, output logic mul,
                            output logic ill, output int lat);
    op = 5'h00; mul = 1'b0; ill = 1'b0; lat = 1;
    if      (opc == 4'hb) op = 5'h01;
    else if (opc == 4'h4) op = 5'h03;
    else if (opc == 4'h5) op = 5'h04;
    else if (opc == 4'h7) op = 5'h05;
    else if (opc == 4'h3) op = 5'h02;
    else if (opc == 4'h2) begin
      if (f == 6'h20 || f == 6'h21 || f == 6'h13) op = 5'h03;
      else if (f == 6'h24) op = 5'h05;
      else if (f == 6'h25) op = 5'h02;
      else if (f == 6'h14) op = 5'h04;
      else if (f == 6'h08) op = 5'h0b;
      else if (f == 6'h27) op = 5'h0a;
      else if (f == 6'h2a) op = 5'h08;
      else if (f == 6'h2b) op = 5'h09;
      else if (f == 6'h00) op = 5'h06;
      else if (f == 6'h02) op = 5'h07;
      else if (f == 6'h18) begin op = 5'h0c; mul = 1'b1; lat = 4; end
      else if (f == 6'h1a) begin op = 5'h0d; mul = 1'b1; lat = 8; end
      else ill = 1'b1;
    end else ill = 1'b1;
  endtask

  // Model state: the EX op and how many EX cycles it still occupies.
  logic       m_valid = 1'b0;
  logic [4:0] m_op = 5'h00;
  logic       m_multi = 1'b0;
  logic       m_ill = 1'b0;
  int         m_rem = 1;

  always @(posedge clk) begin : model
    logic [4:0] d_op;
    logic       d_mul;
    logic       d_ill;
    int         d_lat;
    if (!rst_n || flush_i) begin
      m_valid <= 1'b0; m_op <= 5'h00; m_multi <= 1'b0; m_ill <= 1'b0; m_rem <= 1;
    end else if (stall_i) begin
      m_rem <= m_rem;
    end else if (m_rem > 1) begin
      m_rem <= m_rem - 1;
    end else begin
      ref_decode(opcode_i, funct_i, d_op, d_mul, d_ill, d_lat);
      m_valid <= id_valid_i;
      m_op    <= id_valid_i ? d_op : 5'h00;
      m_multi <= id_valid_i && d_mul;
      m_ill   <= id_valid_i && d_ill;
      m_rem   <= id_valid_i ? d_lat : 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("valid",   32'(ex_valid_o),     32'(m_valid));
      chk("op",      32'(ex_op_o),        32'(m_op));
      chk("multi",   32'(ex_multi_o),     32'(m_multi));
      chk("illegal", 32'(ex_illegal_o),   32'(m_ill));
      chk("hazard",  32'(hazard_stall_o), 32'(m_rem > 1));
      chk("last",    32'(ex_last_o),      32'(m_valid && (m_rem <= 1)));
    end
  end

  // Present an instruction and hold it until the edge that accepts it.
  task automatic send(input logic v, input logic [3:0] o, input logic [5:0] f);
    bit done = 1'b0;
    id_valid_i = v; opcode_i = o; funct_i = f;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!hazard_stall_o && !stall_i) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: got busy expected accepted at %0t", $time);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_op, n_hz, last_at;
    // Reset with a valid instruction present.
    rst_n = 1'b0; id_valid_i = 1'b1; opcode_i = 4'h4;
    @(posedge clk); check_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid",  32'(ex_valid_o), 32'd0);
    chk("rst_op",     32'(ex_op_o), 32'd0);
    chk("rst_hazard", 32'(hazard_stall_o), 32'd0);
    chk("rst_last",   32'(ex_last_o), 32'd0);
    rst_n = 1'b1;

    // Back-to-back I-type stream.
    send(1'b1, 4'h4, 6'h00); chk("s_op4", 32'(ex_op_o), 32'h03); chk("s_last4", 32'(ex_last_o), 32'd1);
    send(1'b1, 4'h5, 6'h00); chk("s_op5", 32'(ex_op_o), 32'h04);
    send(1'b1, 4'hb, 6'h00); chk("s_opb", 32'(ex_op_o), 32'h01);
    send(1'b1, 4'h3, 6'h00); chk("s_op3", 32'(ex_op_o), 32'h02); chk("s_last3", 32'(ex_last_o), 32'd1);

    // R-type including an illegal funct, then a bubble.
    send(1'b1, 4'h2, 6'h2a); chk("r_2a", 32'(ex_op_o), 32'h08);
    send(1'b1, 4'h2, 6'h27); chk("r_27", 32'(ex_op_o), 32'h0a); chk("r_27_ill", 32'(ex_illegal_o), 32'd0);
    send(1'b1, 4'h2, 6'h3f); chk("r_3f", 32'(ex_op_o), 32'h00); chk("r_3f_ill", 32'(ex_illegal_o), 32'd1);
    chk("r_3f_valid", 32'(ex_valid_o), 32'd1);
    send(1'b0, 4'hf, 6'h3f); chk("bub_valid", 32'(ex_valid_o), 32'd0); chk("bub_ill", 32'(ex_illegal_o), 32'd0);

    // MULT followed by an add waiting in ID.
    send(1'b1, 4'h2, 6'h18);
    chk("mul_op", 32'(ex_op_o), 32'h0c); chk("mul_multi", 32'(ex_multi_o), 32'd1);
    id_valid_i = 1'b1; opcode_i = 4'h2; funct_i = 6'h20;
    n_op = 0; n_hz = 0; last_at = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ex_op_o != 5'h0c) break;
      n_op++;
      if (hazard_stall_o) n_hz++;
      if (ex_last_o) last_at = n_op;
    end
    chk("mul_cycles", 32'(n_op), 32'd4);
    chk("mul_hazard", 32'(n_hz), 32'd3);
    chk("mul_last_at", 32'(last_at), 32'd4);
    chk("mul_then_add", 32'(ex_op_o), 32'h03);

    // DIV with a two-cycle downstream stall in the middle.
    send(1'b1, 4'h2, 6'h1a);
    id_valid_i = 1'b0;
    n_op = 0; n_hz = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ex_op_o != 5'h0d) begin stall_i = 1'b0; break; end
      n_op++;
      if (hazard_stall_o) n_hz++;
      stall_i = (n_op == 3 || n_op == 4);
    end
    stall_i = 1'b0;
    chk("div_cycles", 32'(n_op), 32'd10);
    chk("div_hazard", 32'(n_hz), 32'd9);

    // Flush in DIV cycle 3 aborts it; next instruction enters at once.
    send(1'b1, 4'h2, 6'h1a);
    id_valid_i = 1'b1; opcode_i = 4'h4; funct_i = 6'h00;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("fl_pre_hazard", 32'(hazard_stall_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    chk("fl_valid", 32'(ex_valid_o), 32'd0);
    chk("fl_op", 32'(ex_op_o), 32'd0);
    chk("fl_hazard", 32'(hazard_stall_o), 32'd0);
    @(posedge clk); #1;
    chk("fl_next", 32'(ex_op_o), 32'h03);

    // Stall while idle holds EX.
    stall_i = 1'b1; opcode_i = 4'h7;
    @(posedge clk); #1;
    chk("idle_stall", 32'(ex_op_o), 32'h03);
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_release", 32'(ex_op_o), 32'h05);

    id_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
